// File: rtl/uart_port_bridge_pkg.sv
// Shared constants, command layout and FSM encoding for the UART port bridge.
package uart_port_bridge_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OPC_W  = 4;

  // 10 ms at 100 MHz
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1000000;

  localparam logic [OPC_W-1:0] CMD_WRITE = 4'b0010;
  localparam logic [OPC_W-1:0] CMD_READ  = 4'b0011;

  // Command byte as received on the UART
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] port;
  } cmd_t;

  // Eight states in three bits: every encoding is a legal state
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WDATA    = 3'd1,
    ST_WSTROBE  = 3'd2,
    ST_RLATCH   = 3'd3,
    ST_RLOAD    = 3'd4,
    ST_RSEND    = 3'd5,
    ST_RWAIT_LO = 3'd6,
    ST_RWAIT_HI = 3'd7
  } state_e;

endpackage

// File: rtl/uart_port_bridge_frame_timer.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYCLES have elapsed.
module frame_timer
  import uart_port_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  // Count up while enabled; saturate and hold the expired flag once reached
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      expired <= 1'b0;
    end else if (enable && !expired) begin
      r_count <= r_count + CNT_W'(1);
      expired <= (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  end

endmodule

// File: rtl/uart_port_bridge.sv
// Byte-serial command bridge: UART WRITE/READ frames to a 16-port register bus.
module uart_port_bridge
  import uart_port_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rxready,
  input  logic [BYTE_W-1:0] rxdata,
  input  logic              txready,
  output logic              txen,
  output logic [BYTE_W-1:0] txdata,
  output logic [ADDR_W-1:0] port_addr,
  output logic [DATA_W-1:0] port_wdata,
  output logic              port_we,
  output logic              port_re,
  input  logic [DATA_W-1:0] port_rdata,
  output logic              cmd_err
);

  state_e            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [1:0]        r_byte_cnt;

  cmd_t w_cmd;
  logic w_timer_clear;
  logic w_timer_en;
  logic w_expired;

  assign w_cmd         = cmd_t'(rxdata);
  assign w_timer_en    = (r_state == ST_WDATA);
  assign w_timer_clear = rxready || (r_state != ST_WDATA);

  frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_timer_clear),
    .enable  (w_timer_en),
    .expired (w_expired)
  );

  // Frame decoder, write assembly and read-response sequencer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      txen       <= 1'b0;
      txdata     <= '0;
      port_addr  <= '0;
      port_wdata <= '0;
      port_we    <= 1'b0;
      port_re    <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      txen    <= 1'b0;
      port_we <= 1'b0;
      port_re <= 1'b0;
      cmd_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (rxready) begin
            if (w_cmd.opcode == CMD_WRITE) begin
              port_addr  <= w_cmd.port;
              r_byte_cnt <= '0;
              r_state    <= ST_WDATA;
            end else if (w_cmd.opcode == CMD_READ) begin
              port_addr  <= w_cmd.port;
              r_byte_cnt <= '0;
              port_re    <= 1'b1;
              r_state    <= ST_RLATCH;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end

        ST_WDATA: begin
          if (rxready) begin
            port_wdata <= {port_wdata[DATA_W-BYTE_W-1:0], rxdata};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              port_we <= 1'b1;
              r_state <= ST_WSTROBE;
            end
          end else if (w_expired) begin
            cmd_err <= 1'b1;
            r_state <= ST_IDLE;
          end
        end

        // port_we is high this cycle; any coincident byte is dropped
        ST_WSTROBE: r_state <= ST_IDLE;

        // First cycle: port_re is high; second cycle: port_rdata is valid
        ST_RLATCH: begin
          if (!port_re) begin
            r_shift <= port_rdata;
            r_state <= ST_RLOAD;
          end
        end

        ST_RLOAD: begin
          if (txready) begin
            txdata  <= r_shift[DATA_W-1 -: BYTE_W];
            r_shift <= {r_shift[DATA_W-BYTE_W-1:0], BYTE_W'(0)};
            txen    <= 1'b1;
            r_state <= ST_RSEND;
          end
        end

        // txen is high this cycle
        ST_RSEND: r_state <= ST_RWAIT_LO;

        ST_RWAIT_LO: begin
          if (!txready) r_state <= ST_RWAIT_HI;
        end

        ST_RWAIT_HI: begin
          if (txready) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_state    <= (r_byte_cnt == 2'd3) ? ST_IDLE : ST_RLOAD;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_port_bridge.sv
// Scoreboard bench for uart_port_bridge: frames are issued with their expected
// bus/UART events queued; a monitor pops and compares as the DUT responds.
module tb_uart_port_bridge;

  localparam int unsigned TO = 1000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rxready;
  logic [7:0]  rxdata;
  logic        txready;
  logic        txen;
  logic [7:0]  txdata;
  logic [3:0]  port_addr;
  logic [31:0] port_wdata;
  logic        port_we;
  logic        port_re;
  logic [31:0] port_rdata;
  logic        cmd_err;

  always #5 clock = ~clock;

  uart_port_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rxready    (rxready),
    .rxdata     (rxdata),
    .txready    (txready),
    .txen       (txen),
    .txdata     (txdata),
    .port_addr  (port_addr),
    .port_wdata (port_wdata),
    .port_we    (port_we),
    .port_re    (port_re),
    .port_rdata (port_rdata),
    .cmd_err    (cmd_err)
  );

  typedef enum int {EV_WE, EV_RE, EV_TX, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [3:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          passed = 0;
  int          tx_seen = 0;
  int          cyc = 0;
  int          err_cyc = 0;
  int          last_rx_cyc = 0;
  int          busy;
  logic [31:0] port_mem [16];
  logic [31:0] ref_mem  [16];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Register-bus port model: registered read data, write updates storage
  always @(posedge clock) begin
    if (port_re) port_rdata <= port_mem[port_addr];
    if (port_we) port_mem[port_addr] <= port_wdata;
  end

  // UART transmitter model: busy for a random time after each load
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      txready <= 1'b1;
      busy    <= 0;
    end else if (txen) begin
      txready <= 1'b0;
      busy    <= int'($urandom_range(2, 6));
    end else if (!txready) begin
      if (busy == 0) txready <= 1'b1;
      else           busy    <= busy - 1;
    end
  end

  task automatic expect_ev(input ev_kind_e kind, input logic [3:0] addr, input logic [31:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_%s: got addr %h data %h, required no event", kind.name(), addr, data);
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("event_kind_%s", e.kind.name()), 32'(kind), 32'(e.kind));
    if (kind == e.kind) begin
      case (kind)
        EV_WE: begin
          check("we_addr", 32'(addr), 32'(e.addr));
          check("we_data", data, e.data);
        end
        EV_RE: check("re_addr", 32'(addr), 32'(e.addr));
        EV_TX: check("tx_byte", data, e.data);
        default: ;
      endcase
    end
  endtask

  // Monitor: sample away from the active edge
  always @(negedge clock) begin
    if (reset_n) begin
      if (txen) begin
        tx_seen++;
        check("txen_while_txready", 32'(txready), 32'd1);
        expect_ev(EV_TX, 4'h0, {24'h0, txdata});
      end
      if (port_we) expect_ev(EV_WE, port_addr, port_wdata);
      if (port_re) expect_ev(EV_RE, port_addr, 32'h0);
      if (cmd_err) begin
        err_cyc = cyc;
        expect_ev(EV_ERR, 4'h0, 32'h0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    rxready = 1'b1;
    rxdata  = b;
    last_rx_cyc = cyc;
    @(posedge clock); #1;
    rxready = 1'b0;
    repeat ($urandom_range(0, 3)) @(posedge clock);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clock);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (16) @(posedge clock);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    exp_q.push_back('{kind: EV_WE, addr: a, data: d});
    ref_mem[a] = d;
    send_byte({4'h2, a});
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
    wait_drain();
  endtask

  task automatic do_read(input logic [3:0] a, input bit junk);
    logic [31:0] d;
    d = ref_mem[a];
    exp_q.push_back('{kind: EV_RE, addr: a, data: 32'h0});
    for (int i = 3; i >= 0; i--)
      exp_q.push_back('{kind: EV_TX, addr: 4'h0, data: {24'h0, d[i*8 +: 8]}});
    send_byte({4'h3, a});
    if (junk) begin
      send_byte(8'h45);
      send_byte(8'h2A);
    end
    wait_drain();
  endtask

  task automatic do_illegal(input logic [7:0] b);
    exp_q.push_back('{kind: EV_ERR, addr: 4'h0, data: 32'h0});
    send_byte(b);
    wait_drain();
  endtask

  initial begin
    int unsigned sel;
    logic [3:0]  a;
    logic [3:0]  op;
    int          n;
    int          base;
    int          lat;

    reset_n = 1'b0;
    rxready = 1'b0;
    rxdata  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("rst_txen",       32'(txen),       32'd0);
    check("rst_port_we",    32'(port_we),    32'd0);
    check("rst_port_re",    32'(port_re),    32'd0);
    check("rst_cmd_err",    32'(cmd_err),    32'd0);
    check("rst_txdata",     32'(txdata),     32'd0);
    check("rst_port_addr",  32'(port_addr),  32'd0);
    check("rst_port_wdata", port_wdata,      32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Give every port a known value
    for (int i = 0; i < 16; i++) do_write(4'(i), $urandom());

    do_write(4'h2, 32'h0000000E);
    do_write(4'h3, 32'hFFFFFFB1);
    do_write(4'h4, 32'h12345678);
    do_read(4'h4, 1'b1);
    do_illegal(8'h45);
    do_write(4'h9, 32'hDEADBEEF);

    // Incomplete write frame times out
    exp_q.push_back('{kind: EV_ERR, addr: 4'h0, data: 32'h0});
    err_cyc = 0;
    send_byte(8'h26);
    send_byte(8'h01);
    send_byte(8'h02);
    base = last_rx_cyc;
    wait_drain();
    lat = err_cyc - base;
    check("timeout_latency_in_range", 32'((lat >= int'(TO)) && (lat <= int'(TO) + 5)), 32'd1);
    do_write(4'h6, $urandom());
    do_read(4'h6, 1'b0);

    // Reset in the middle of a read response
    base = tx_seen;
    exp_q.push_back('{kind: EV_RE, addr: 4'h1, data: 32'h0});
    for (int i = 3; i >= 0; i--)
      exp_q.push_back('{kind: EV_TX, addr: 4'h0, data: {24'h0, ref_mem[1][i*8 +: 8]}});
    send_byte(8'h31);
    n = 0;
    while (tx_seen < base + 2 && n < 500) begin
      @(posedge clock);
      n++;
    end
    check("midread_tx_before_reset", 32'(tx_seen - base), 32'd2);
    #1 reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_txen",      32'(txen),      32'd0);
    check("midrst_txdata",    32'(txdata),    32'd0);
    check("midrst_port_addr", 32'(port_addr), 32'd0);
    check("midrst_port_wdata", port_wdata,    32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    base = tx_seen;
    repeat (60) @(posedge clock);
    check("no_tx_after_reset", 32'(tx_seen - base), 32'd0);
    do_read(4'h1, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 2);
      a   = 4'($urandom_range(0, 15));
      case (sel)
        0: do_write(a, $urandom());
        1: do_read(a, ($urandom_range(0, 1) == 1));
        default: begin
          op = 4'($urandom_range(0, 15));
          if (op == 4'h2 || op == 4'h3) op = 4'hF;
          do_illegal({op, a});
        end
      endcase
    end

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
